emu_run_ctrl: RTL and testbench

EMU_RUN_CTRL -- requirements
Module: emu_run_ctrl

---
 rtl/emu_sys_ctrl_pkg.sv | 36 +++
 rtl/emu_trig_bank.sv | 62 ++++++
 rtl/emu_run_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_emu_run_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/emu_sys_ctrl_pkg.sv
// Shared constants for the emulator run controller: register map,
// run-state encoding and PAUSE_CAUSE bit layout.
package emu_sys_ctrl_pkg;

  localparam logic [11:0] ADDR_MODE_CTRL   = 12'h000;
  localparam logic [11:0] ADDR_STEP_CNT    = 12'h004;
  localparam logic [11:0] ADDR_TICK_CNT_LO = 12'h008;
  localparam logic [11:0] ADDR_TICK_CNT_HI = 12'h00C;
  localparam logic [11:0] ADDR_SCAN_CTRL   = 12'h010;
  localparam logic [11:0] ADDR_TICK_CMP_LO = 12'h014;
  localparam logic [11:0] ADDR_TICK_CMP_HI = 12'h018;
  localparam logic [11:0] ADDR_PAUSE_CAUSE = 12'h01C;

  // Trigger bank regions, selected by address bits [11:7]; bits [6:2]
  // pick the 32-bit bank inside a region.
  localparam logic [4:0] RGN_TRIG_STAT = 5'h08;  // 0x400-0x47C
  localparam logic [4:0] RGN_TRIG_EN   = 5'h09;  // 0x480-0x4FC
  localparam logic [4:0] RGN_TRIG_EDGE = 5'h0A;  // 0x500-0x57C

  typedef enum logic [1:0] {
    ST_PAUSED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STOPPING = 2'd2
  } run_state_t;

  localparam int unsigned CAUSE_HOST    = 0;
  localparam int unsigned CAUSE_STEP    = 1;
  localparam int unsigned CAUSE_CMP     = 2;
  localparam int unsigned CAUSE_TRIG    = 3;
  localparam int unsigned CAUSE_IDX_LSB = 16;

  function automatic int unsigned trig_banks(input int unsigned n);
    return (n + 31) / 32;
  endfunction

endpackage

// File: rtl/emu_trig_bank.sv
// One bank of 32 model triggers: enable/edge config, previous-level
// history, latched status and lowest-index encode of the current hits.
// Bits at or above NBITS are forced to zero everywhere.
module emu_trig_bank
  import emu_sys_ctrl_pkg::*;
#(
  parameter int unsigned NBITS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] trig,
  input  logic        load_prev,
  input  logic        advance,
  input  logic        en_wen,
  input  logic        edge_wen,
  input  logic [31:0] wdata,
  output logic [31:0] en_q,
  output logic [31:0] edge_q,
  output logic [31:0] stat_q,
  output logic        any_hit,
  output logic [4:0]  low_idx
);

  localparam logic [32:0] MASK_EXT = (33'd1 << NBITS) - 33'd1;
  localparam logic [31:0] MASK     = MASK_EXT[31:0];

  logic [31:0] prev_q;
  logic [31:0] hit;

  // Per-bit hit: rising edge when edge mode is selected, else high level.
  always_comb begin
    hit     = en_q & ((edge_q & trig & ~prev_q) | (~edge_q & trig));
    any_hit = |hit;
    low_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (hit[i]) low_idx = 5'(i);
    end
  end

  // Host-written configuration, masked to the implemented bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q   <= '0;
      edge_q <= '0;
    end else begin
      if (en_wen)   en_q   <= wdata & MASK;
      if (edge_wen) edge_q <= wdata & MASK;
    end
  end

  // Trigger history and status: seeded at run start, advanced per model tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      stat_q <= '0;
    end else begin
      if (load_prev || advance) prev_q <= trig & MASK;
      if (advance)              stat_q <= hit;
    end
  end

endmodule

// File: rtl/emu_run_ctrl.sv
// Emulator run controller: host-visible run/stop FSM with step, tick-compare
// and trigger stop conditions, plus the scan DMA kick-off register.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   ST_PAUSED   | model frozen; counters writable; RUN write starts a run
//   ST_RUNNING  | model advancing on tick; pauses on step/cmp/trigger hit
//   ST_STOPPING | host asked to stop; pauses on the next tick
module emu_run_ctrl
  import emu_sys_ctrl_pkg::*;
#(
  parameter int unsigned TRIG_COUNT = 1,
  parameter int unsigned TICK_WIDTH = 64
) (
  input  logic                  host_clk,
  input  logic                  host_rst_n,
  input  logic                  tick,
  input  logic                  model_busy,
  output logic                  run_mode,
  output logic                  scan_mode,
  input  logic [TRIG_COUNT-1:0] trig,
  input  logic                  ctrl_wen,
  input  logic [11:0]           ctrl_waddr,
  input  logic [31:0]           ctrl_wdata,
  input  logic                  ctrl_ren,
  input  logic [11:0]           ctrl_raddr,
  output logic [31:0]           ctrl_rdata,
  output logic                  dma_start,
  output logic                  dma_direction,
  input  logic                  dma_running
);

  localparam int unsigned NBANK = trig_banks(TRIG_COUNT);
  localparam logic [TICK_WIDTH-1:0] TICK_ONE = {{(TICK_WIDTH-1){1'b0}}, 1'b1};

  run_state_t            state;
  logic                  cmp_en;
  logic [31:0]           pause_cause;
  logic [31:0]           step_cnt;
  logic [TICK_WIDTH-1:0] tick_cnt;
  logic [TICK_WIDTH-1:0] tick_cmp;
  logic [TICK_WIDTH-1:0] tick_cnt_inc;

  logic        mode_wr, go, advance, paused;
  logic        step_hit, cmp_hit, trig_hit, pause_now;
  logic [9:0]  trig_idx;
  logic [31:0] cause_next;

  logic [NBANK*32-1:0] trig_pad;
  logic [31:0]         bank_en   [NBANK];
  logic [31:0]         bank_edge [NBANK];
  logic [31:0]         bank_stat [NBANK];
  logic [4:0]          bank_low  [NBANK];
  logic [NBANK-1:0]    bank_any;
  logic [NBANK-1:0]    bank_en_wen;
  logic [NBANK-1:0]    bank_edge_wen;

  assign paused       = (state == ST_PAUSED);
  assign mode_wr      = ctrl_wen && (ctrl_waddr == ADDR_MODE_CTRL);
  assign go           = mode_wr && ctrl_wdata[0] && paused;
  assign advance      = run_mode && tick;
  assign tick_cnt_inc = tick_cnt + TICK_ONE;
  assign step_hit     = (step_cnt == 32'd1);
  assign cmp_hit      = cmp_en && tick && (tick_cnt_inc == tick_cmp);
  assign trig_hit     = |bank_any;
  assign pause_now    = !paused && tick &&
                        ((state == ST_STOPPING) || step_hit || cmp_hit || trig_hit);
  assign dma_start    = host_rst_n && ctrl_wen && (ctrl_waddr == ADDR_SCAN_CTRL) &&
                        ctrl_wdata[0];

  // Zero-extend the trigger vector to a whole number of banks.
  always_comb begin
    trig_pad                 = '0;
    trig_pad[TRIG_COUNT-1:0] = trig;
  end

  // Per-bank config write strobes.
  always_comb begin
    for (int b = 0; b < NBANK; b++) begin
      bank_en_wen[b]   = ctrl_wen && (ctrl_waddr[1:0] == 2'b00) &&
                         (ctrl_waddr[11:7] == RGN_TRIG_EN) && (ctrl_waddr[6:2] == 5'(b));
      bank_edge_wen[b] = ctrl_wen && (ctrl_waddr[1:0] == 2'b00) &&
                         (ctrl_waddr[11:7] == RGN_TRIG_EDGE) && (ctrl_waddr[6:2] == 5'(b));
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    localparam int unsigned BITS = ((TRIG_COUNT - b*32) >= 32) ? 32 : (TRIG_COUNT - b*32);
    emu_trig_bank #(.NBITS(BITS)) u_bank (
      .clk       (host_clk),
      .rst_n     (host_rst_n),
      .trig      (trig_pad[b*32 +: 32]),
      .load_prev (go),
      .advance   (advance),
      .en_wen    (bank_en_wen[b]),
      .edge_wen  (bank_edge_wen[b]),
      .wdata     (ctrl_wdata),
      .en_q      (bank_en[b]),
      .edge_q    (bank_edge[b]),
      .stat_q    (bank_stat[b]),
      .any_hit   (bank_any[b]),
      .low_idx   (bank_low[b])
    );
  end

  // Lowest global trigger index and the cause word captured on a pause.
  always_comb begin
    trig_idx = '0;
    for (int b = NBANK - 1; b >= 0; b--) begin
      if (bank_any[b]) trig_idx = {5'(b), bank_low[b]};
    end
    cause_next             = '0;
    cause_next[CAUSE_HOST] = (state == ST_STOPPING);
    cause_next[CAUSE_STEP] = step_hit;
    cause_next[CAUSE_CMP]  = cmp_hit;
    cause_next[CAUSE_TRIG] = trig_hit;
    if (trig_hit) cause_next[CAUSE_IDX_LSB +: 10] = trig_idx;
  end

  // Run FSM with its registered mode outputs and pause cause.
  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) begin
      state       <= ST_PAUSED;
      run_mode    <= 1'b0;
      scan_mode   <= 1'b0;
      cmp_en      <= 1'b0;
      pause_cause <= '0;
    end else begin
      if (mode_wr) begin
        scan_mode <= ctrl_wdata[1];
        cmp_en    <= ctrl_wdata[4];
      end
      case (state)
        ST_PAUSED: begin
          if (go) begin
            state       <= ST_RUNNING;
            run_mode    <= 1'b1;
            pause_cause <= '0;
          end
        end
        ST_RUNNING, ST_STOPPING: begin
          // A pause wins over any host write landing in the same cycle.
          if (pause_now) begin
            state       <= ST_PAUSED;
            run_mode    <= 1'b0;
            pause_cause <= cause_next;
          end else if (state == ST_RUNNING && mode_wr && !ctrl_wdata[0]) begin
            state <= ST_STOPPING;
          end
        end
        default: begin
          state    <= ST_PAUSED;
          run_mode <= 1'b0;
        end
      endcase
    end
  end

  // Step down-counter and tick counter: count while running, host-loaded while paused.
  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) begin
      step_cnt <= '0;
      tick_cnt <= '0;
    end else if (advance) begin
      if (step_cnt != 32'd0) step_cnt <= step_cnt - 32'd1;
      tick_cnt <= tick_cnt_inc;
    end else if (paused && ctrl_wen) begin
      if (ctrl_waddr == ADDR_STEP_CNT)    step_cnt <= ctrl_wdata;
      if (ctrl_waddr == ADDR_TICK_CNT_LO) tick_cnt[31:0] <= ctrl_wdata;
      if (ctrl_waddr == ADDR_TICK_CNT_HI) tick_cnt[TICK_WIDTH-1:32] <= ctrl_wdata[TICK_WIDTH-33:0];
    end
  end

  // Tick compare value and DMA direction (frozen while a transfer is running).
  always_ff @(posedge host_clk or negedge host_rst_n) begin
    if (!host_rst_n) begin
      tick_cmp      <= '0;
      dma_direction <= 1'b0;
    end else if (ctrl_wen) begin
      if (ctrl_waddr == ADDR_TICK_CMP_LO) tick_cmp[31:0] <= ctrl_wdata;
      if (ctrl_waddr == ADDR_TICK_CMP_HI) tick_cmp[TICK_WIDTH-1:32] <= ctrl_wdata[TICK_WIDTH-33:0];
      if (ctrl_waddr == ADDR_SCAN_CTRL && !dma_running) dma_direction <= ctrl_wdata[1];
    end
  end

  // Host read mux; anything unmapped reads zero.
  always_comb begin
    ctrl_rdata = '0;
    if (ctrl_ren && ctrl_raddr[1:0] == 2'b00) begin
      case (ctrl_raddr)
        ADDR_MODE_CTRL:   ctrl_rdata = {27'd0, cmp_en, model_busy, (state == ST_STOPPING),
                                        scan_mode, run_mode};
        ADDR_STEP_CNT:    ctrl_rdata = step_cnt;
        ADDR_TICK_CNT_LO: ctrl_rdata = tick_cnt[31:0];
        ADDR_TICK_CNT_HI: ctrl_rdata = 32'(tick_cnt[TICK_WIDTH-1:32]);
        ADDR_SCAN_CTRL:   ctrl_rdata = {30'd0, dma_direction, dma_running};
        ADDR_TICK_CMP_LO: ctrl_rdata = tick_cmp[31:0];
        ADDR_TICK_CMP_HI: ctrl_rdata = 32'(tick_cmp[TICK_WIDTH-1:32]);
        ADDR_PAUSE_CAUSE: ctrl_rdata = pause_cause;
        default: begin
          for (int b = 0; b < NBANK; b++) begin
            if (ctrl_raddr[6:2] == 5'(b)) begin
              case (ctrl_raddr[11:7])
                RGN_TRIG_STAT: ctrl_rdata = bank_stat[b];
                RGN_TRIG_EN:   ctrl_rdata = bank_en[b];
                RGN_TRIG_EDGE: ctrl_rdata = bank_edge[b];
                default:       ctrl_rdata = '0;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_emu_run_ctrl.sv
// Directed bench for emu_run_ctrl with 40 triggers and a 48-bit tick counter.
module tb_emu_run_ctrl;

  logic        host_clk = 1'b0;
  logic        host_rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        model_busy = 1'b0;
  logic        run_mode, scan_mode;
  logic [39:0] trig = '0;
  logic        ctrl_wen = 1'b0;
  logic [11:0] ctrl_waddr = '0;
  logic [31:0] ctrl_wdata = '0;
  logic        ctrl_ren = 1'b0;
  logic [11:0] ctrl_raddr = '0;
  logic [31:0] ctrl_rdata;
  logic        dma_start, dma_direction;
  logic        dma_running = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  emu_run_ctrl #(.TRIG_COUNT(40), .TICK_WIDTH(48)) dut (
    .host_clk(host_clk), .host_rst_n(host_rst_n), .tick(tick), .model_busy(model_busy),
    .run_mode(run_mode), .scan_mode(scan_mode), .trig(trig),
    .ctrl_wen(ctrl_wen), .ctrl_waddr(ctrl_waddr), .ctrl_wdata(ctrl_wdata),
    .ctrl_ren(ctrl_ren), .ctrl_raddr(ctrl_raddr), .ctrl_rdata(ctrl_rdata),
    .dma_start(dma_start), .dma_direction(dma_direction), .dma_running(dma_running)
  );

  always #5 host_clk = ~host_clk;

  // Pop the oldest expected value and compare it with what the DUT shows.
  task automatic score(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    exp = exp_q.pop_front();
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    exp_q.push_back(exp);
    score(tag, obs);
  endtask

  // All tasks below start and end just after a falling edge.
  task automatic rd_chk(input string tag, input logic [11:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    ctrl_ren   = 1'b1;
    ctrl_raddr = addr;
    #1;
    score(tag, ctrl_rdata);
    ctrl_ren = 1'b0;
    @(negedge host_clk);
  endtask

  task automatic wr(input logic [11:0] addr, input logic [31:0] data);
    ctrl_wen   = 1'b1;
    ctrl_waddr = addr;
    ctrl_wdata = data;
    @(negedge host_clk);
    ctrl_wen = 1'b0;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1;
      @(negedge host_clk);
      tick = 1'b0;
    end
  endtask

  initial begin
    // Reset held: outputs quiet, dma_start suppressed even with a kick write.
    @(negedge host_clk);
    @(negedge host_clk);
    chk("rst_run_mode", 32'(run_mode), 32'd0);
    chk("rst_scan_mode", 32'(scan_mode), 32'd0);
    chk("rst_dma_dir", 32'(dma_direction), 32'd0);
    ctrl_wen = 1'b1; ctrl_waddr = 12'h010; ctrl_wdata = 32'h3;
    #1;
    chk("rst_dma_start", 32'(dma_start), 32'd0);
    ctrl_wen = 1'b0;
    @(negedge host_clk);
    host_rst_n = 1'b1;
    @(negedge host_clk);
    rd_chk("rst_mode_ctrl", 12'h000, 32'h0);
    rd_chk("rst_cause", 12'h01C, 32'h0);
    rd_chk("rst_dma_dir_rd", 12'h010, 32'h0);

    // Unmapped / misaligned accesses read zero.
    wr(12'h020, 32'hFFFF_FFFF);
    rd_chk("unmapped_020", 12'h020, 32'h0);
    rd_chk("misaligned_002", 12'h002, 32'h0);

    // Step: 5 ticks then pause with step cause.
    wr(12'h004, 32'd5);
    wr(12'h000, 32'h1);
    chk("step_run_mode", 32'(run_mode), 32'd1);
    tick_n(4);
    rd_chk("step_mode_mid", 12'h000, 32'h1);
    rd_chk("step_cnt_mid", 12'h004, 32'd1);
    tick_n(1);
    chk("step_paused", 32'(run_mode), 32'd0);
    rd_chk("step_ticks", 12'h008, 32'd5);
    rd_chk("step_cause", 12'h01C, 32'h2);
    rd_chk("step_cnt_end", 12'h004, 32'd0);
    tick_n(2);
    rd_chk("paused_no_count", 12'h008, 32'd5);

    // Tick counter width boundary and wrap.
    wr(12'h00C, 32'hFFFF_FFFF);
    rd_chk("tick_hi_width", 12'h00C, 32'h0000_FFFF);
    wr(12'h008, 32'hFFFF_FFFF);
    wr(12'h004, 32'd1);
    wr(12'h000, 32'h1);
    rd_chk("run_clears_cause", 12'h01C, 32'h0);
    tick_n(1);
    chk("wrap_paused", 32'(run_mode), 32'd0);
    rd_chk("wrap_lo", 12'h008, 32'h0);
    rd_chk("wrap_hi", 12'h00C, 32'h0);
    rd_chk("wrap_cause", 12'h01C, 32'h2);

    // Compare: pause with counter equal to TICK_CMP.
    wr(12'h014, 32'd100);
    wr(12'h018, 32'd0);
    rd_chk("cmp_lo_rd", 12'h014, 32'd100);
    wr(12'h000, 32'h11);
    tick_n(99);
    chk("cmp_not_yet", 32'(run_mode), 32'd1);
    rd_chk("cmp_cnt99", 12'h008, 32'd99);
    tick_n(1);
    chk("cmp_paused", 32'(run_mode), 32'd0);
    rd_chk("cmp_cnt", 12'h008, 32'd100);
    rd_chk("cmp_cause", 12'h01C, 32'h4);
    rd_chk("cmp_mode", 12'h000, 32'h10);
    wr(12'h000, 32'h0);
    rd_chk("stop_while_paused", 12'h000, 32'h0);

    // Rising-edge stop on trigger 37; enable bits past the trigger count read back as zero.
    wr(12'h484, 32'hFFFF_FF20);
    wr(12'h504, 32'h0000_0020);
    rd_chk("trig_en_mask", 12'h484, 32'h20);
    rd_chk("trig_edge_rd", 12'h504, 32'h20);
    rd_chk("trig_bank2_none", 12'h488, 32'h0);
    trig[37] = 1'b1;
    @(negedge host_clk);
    wr(12'h000, 32'h1);
    tick_n(3);
    chk("edge_high_no_pause", 32'(run_mode), 32'd1);
    trig[37] = 1'b0;
    tick_n(1);
    chk("edge_fall_no_pause", 32'(run_mode), 32'd1);
    trig[37] = 1'b1;
    tick_n(1);
    chk("edge_rise_pause", 32'(run_mode), 32'd0);
    rd_chk("edge_cause", 12'h01C, 32'h0025_0008);
    rd_chk("edge_stat1", 12'h404, 32'h20);
    rd_chk("edge_stat0", 12'h400, 32'h0);
    wr(12'h484, 32'h0);

    // Host stop, then a RUN write racing the pausing tick.
    wr(12'h000, 32'h1);
    rd_chk("host_run", 12'h000, 32'h1);
    wr(12'h000, 32'h0);
    rd_chk("host_stopping", 12'h000, 32'h5);
    chk("stopping_run_mode", 32'(run_mode), 32'd1);
    tick = 1'b1; ctrl_wen = 1'b1; ctrl_waddr = 12'h000; ctrl_wdata = 32'h1;
    @(negedge host_clk);
    tick = 1'b0; ctrl_wen = 1'b0;
    chk("host_paused", 32'(run_mode), 32'd0);
    rd_chk("host_cause", 12'h01C, 32'h1);
    rd_chk("host_mode_after", 12'h000, 32'h0);
    wr(12'h000, 32'h2);
    chk("scan_mode_port", 32'(scan_mode), 32'd1);
    rd_chk("scan_mode_rd", 12'h000, 32'h2);

    // DMA kick-off and direction freeze while running.
    ctrl_wen = 1'b1; ctrl_waddr = 12'h010; ctrl_wdata = 32'h3;
    #1;
    chk("dma_start_pulse", 32'(dma_start), 32'd1);
    @(negedge host_clk);
    ctrl_wen = 1'b0;
    #1;
    chk("dma_start_drop", 32'(dma_start), 32'd0);
    chk("dma_dir_set", 32'(dma_direction), 32'd1);
    @(negedge host_clk);
    rd_chk("scan_ctrl_rd", 12'h010, 32'h2);
    dma_running = 1'b1;
    wr(12'h010, 32'h0);
    chk("dma_dir_frozen", 32'(dma_direction), 32'd1);
    rd_chk("scan_ctrl_running", 12'h010, 32'h3);
    dma_running = 1'b0;

    // Reset mid-run clears everything immediately.
    wr(12'h014, 32'h0000_FFFF);
    wr(12'h004, 32'd7);
    wr(12'h484, 32'h20);
    wr(12'h000, 32'h13);
    tick_n(2);
    chk("pre_rst_running", 32'(run_mode), 32'd1);
    #2;
    host_rst_n = 1'b0;
    #1;
    chk("async_rst_run_mode", 32'(run_mode), 32'd0);
    chk("async_rst_scan", 32'(scan_mode), 32'd0);
    chk("async_rst_dma_dir", 32'(dma_direction), 32'd0);
    @(negedge host_clk);
    rd_chk("rst_rd_mode", 12'h000, 32'h0);
    rd_chk("rst_rd_step", 12'h004, 32'h0);
    rd_chk("rst_rd_tick_lo", 12'h008, 32'h0);
    rd_chk("rst_rd_tick_hi", 12'h00C, 32'h0);
    rd_chk("rst_rd_cmp_lo", 12'h014, 32'h0);
    rd_chk("rst_rd_cause", 12'h01C, 32'h0);
    rd_chk("rst_rd_en1", 12'h484, 32'h0);
    rd_chk("rst_rd_edge1", 12'h504, 32'h0);
    rd_chk("rst_rd_stat1", 12'h404, 32'h0);
    ctrl_wen = 1'b1; ctrl_waddr = 12'h010; ctrl_wdata = 32'h1;
    #1;
    chk("rst_mid_dma_start", 32'(dma_start), 32'd0);
    ctrl_wen = 1'b0;
    @(negedge host_clk);
    host_rst_n = 1'b1;
    @(negedge host_clk);
    rd_chk("post_rst_mode", 12'h000, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
